// File: rtl/tl_pkg.sv
// TileLink-UL shared definitions: opcodes, field widths, A payload bundle,
// arbiter state encoding and the beat-count helper.
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  localparam int OP_W      = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 4;
  localparam int ADDR_W    = 31;
  localparam int MASK_W    = 8;
  localparam int DATA_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_BURST
  } arb_st_t;

  typedef struct packed {
    logic [OP_W-1:0]      opcode;
    logic [A_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [ADDR_W-1:0]    address;
    logic [MASK_W-1:0]    mask;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_a_t;

  // Only data-bearing opcodes (0..3) carry more than one 8-byte beat.
  function automatic logic [15:0] tl_num_beats(
    input logic [OP_W-1:0]   opcode,
    input logic [SIZE_W-1:0] size
  );
    logic [15:0] b;
    b = 16'd1;
    if (!opcode[2] && size > 4'd3)
      b = 16'd1 << (size - 4'd3);
    return b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic rr_last,
  output logic sel
);

  assign sel = (v0 & v1) ? ~rr_last : v1;

endmodule

// File: rtl/tl_client_arbiter_2to1.sv
// Shares one TL-UL client port between two requesters: round-robin A
// arbitration with burst-locked grant, D routed on the source MSB.
module tl_client_arbiter_2to1
  import tl_pkg::*;
#(
  parameter int SRC_W    = 2,
  parameter int MAX_LGSZ = 6
) (
  input  logic                 clock,
  input  logic                 reset,

  output logic                 in0_a_ready,
  input  logic                 in0_a_valid,
  input  logic [OP_W-1:0]      in0_a_bits_opcode,
  input  logic [A_PARAM_W-1:0] in0_a_bits_param,
  input  logic [SIZE_W-1:0]    in0_a_bits_size,
  input  logic [SRC_W-1:0]     in0_a_bits_source,
  input  logic [ADDR_W-1:0]    in0_a_bits_address,
  input  logic [MASK_W-1:0]    in0_a_bits_mask,
  input  logic [DATA_W-1:0]    in0_a_bits_data,
  input  logic                 in0_a_bits_corrupt,
  input  logic                 in0_d_ready,
  output logic                 in0_d_valid,
  output logic [OP_W-1:0]      in0_d_bits_opcode,
  output logic [D_PARAM_W-1:0] in0_d_bits_param,
  output logic [SIZE_W-1:0]    in0_d_bits_size,
  output logic [SRC_W-1:0]     in0_d_bits_source,
  output logic                 in0_d_bits_sink,
  output logic                 in0_d_bits_denied,
  output logic [DATA_W-1:0]    in0_d_bits_data,
  output logic                 in0_d_bits_corrupt,

  output logic                 in1_a_ready,
  input  logic                 in1_a_valid,
  input  logic [OP_W-1:0]      in1_a_bits_opcode,
  input  logic [A_PARAM_W-1:0] in1_a_bits_param,
  input  logic [SIZE_W-1:0]    in1_a_bits_size,
  input  logic [SRC_W-1:0]     in1_a_bits_source,
  input  logic [ADDR_W-1:0]    in1_a_bits_address,
  input  logic [MASK_W-1:0]    in1_a_bits_mask,
  input  logic [DATA_W-1:0]    in1_a_bits_data,
  input  logic                 in1_a_bits_corrupt,
  input  logic                 in1_d_ready,
  output logic                 in1_d_valid,
  output logic [OP_W-1:0]      in1_d_bits_opcode,
  output logic [D_PARAM_W-1:0] in1_d_bits_param,
  output logic [SIZE_W-1:0]    in1_d_bits_size,
  output logic [SRC_W-1:0]     in1_d_bits_source,
  output logic                 in1_d_bits_sink,
  output logic                 in1_d_bits_denied,
  output logic [DATA_W-1:0]    in1_d_bits_data,
  output logic                 in1_d_bits_corrupt,

  input  logic                 out_a_ready,
  output logic                 out_a_valid,
  output logic [OP_W-1:0]      out_a_bits_opcode,
  output logic [A_PARAM_W-1:0] out_a_bits_param,
  output logic [SIZE_W-1:0]    out_a_bits_size,
  output logic [SRC_W:0]       out_a_bits_source,
  output logic [ADDR_W-1:0]    out_a_bits_address,
  output logic [MASK_W-1:0]    out_a_bits_mask,
  output logic [DATA_W-1:0]    out_a_bits_data,
  output logic                 out_a_bits_corrupt,
  output logic                 out_d_ready,
  input  logic                 out_d_valid,
  input  logic [OP_W-1:0]      out_d_bits_opcode,
  input  logic [D_PARAM_W-1:0] out_d_bits_param,
  input  logic [SIZE_W-1:0]    out_d_bits_size,
  input  logic [SRC_W:0]       out_d_bits_source,
  input  logic                 out_d_bits_sink,
  input  logic                 out_d_bits_denied,
  input  logic [DATA_W-1:0]    out_d_bits_data,
  input  logic                 out_d_bits_corrupt
);

  localparam int CW = MAX_LGSZ - 3;
  localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_LGSZ);

  arb_st_t        st, st_n;
  logic           grant, grant_n;
  logic           rr_last, rr_last_n;
  logic [CW-1:0]  beats_left, beats_left_n;

  logic           arb_sel;
  logic           cur;
  logic           v_cur;
  logic           fire;
  logic [15:0]    beats;
  tl_a_t          a0, a1, a_cur;
  logic [SRC_W-1:0] src_cur;
  logic           d_idx;

  rr_arb2 u_rr (
    .v0      (in0_a_valid),
    .v1      (in1_a_valid),
    .rr_last (rr_last),
    .sel     (arb_sel)
  );

  assign a0 = '{
    opcode:  in0_a_bits_opcode,
    param:   in0_a_bits_param,
    size:    in0_a_bits_size,
    address: in0_a_bits_address,
    mask:    in0_a_bits_mask,
    data:    in0_a_bits_data,
    corrupt: in0_a_bits_corrupt
  };

  assign a1 = '{
    opcode:  in1_a_bits_opcode,
    param:   in1_a_bits_param,
    size:    in1_a_bits_size,
    address: in1_a_bits_address,
    mask:    in1_a_bits_mask,
    data:    in1_a_bits_data,
    corrupt: in1_a_bits_corrupt
  };

  // Fresh arbitration only in IDLE; otherwise the mux is locked to grant.
  assign cur     = (st == ST_IDLE) ? arb_sel : grant;
  assign a_cur   = cur ? a1 : a0;
  assign src_cur = cur ? in1_a_bits_source : in0_a_bits_source;
  assign v_cur   = cur ? in1_a_valid : in0_a_valid;

  assign out_a_valid = ~reset & v_cur;
  assign in0_a_ready = ~reset & ~cur & out_a_ready;
  assign in1_a_ready = ~reset &  cur & out_a_ready;
  assign fire        = out_a_valid & out_a_ready;
  assign beats       = tl_num_beats(a_cur.opcode, a_cur.size);

  assign out_a_bits_opcode  = a_cur.opcode;
  assign out_a_bits_param   = a_cur.param;
  assign out_a_bits_size    = a_cur.size;
  assign out_a_bits_source  = {cur, src_cur};
  assign out_a_bits_address = a_cur.address;
  assign out_a_bits_mask    = a_cur.mask;
  assign out_a_bits_data    = a_cur.data;
  assign out_a_bits_corrupt = a_cur.corrupt;

  always_comb begin
    st_n         = st;
    grant_n      = grant;
    rr_last_n    = rr_last;
    beats_left_n = beats_left;
    unique case (st)
      ST_IDLE, ST_HOLD: begin
        if (fire) begin
          rr_last_n = cur;
          if (beats > 16'd1) begin
            st_n         = ST_BURST;
            grant_n      = cur;
            beats_left_n = CW'(beats - 16'd1);
          end else begin
            st_n = ST_IDLE;
          end
        end else if (v_cur) begin
          st_n    = ST_HOLD;
          grant_n = cur;
        end
      end
      ST_BURST: begin
        if (fire) begin
          beats_left_n = beats_left - CW'(1);
          if (beats_left == CW'(1))
            st_n = ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= ST_IDLE;
      grant      <= 1'b0;
      rr_last    <= 1'b1;
      beats_left <= '0;
    end else begin
      st         <= st_n;
      grant      <= grant_n;
      rr_last    <= rr_last_n;
      beats_left <= beats_left_n;
    end
  end

  assert property (@(posedge clock) disable iff (reset)
    out_a_valid |-> a_cur.size <= MAX_SZ);

  // D path is stateless: valid steered by source MSB, payload fans out.
  assign d_idx       = out_d_bits_source[SRC_W];
  assign in0_d_valid = ~reset & out_d_valid & ~d_idx;
  assign in1_d_valid = ~reset & out_d_valid &  d_idx;
  assign out_d_ready = ~reset & (d_idx ? in1_d_ready : in0_d_ready);

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;

  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_client_arbiter_2to1.sv
// Scoreboard bench for the 2:1 TL-UL client arbiter: directed A/D traffic,
// expected beats queued at issue and checked by negedge monitors.
module tb_tl_client_arbiter_2to1;

  logic        clock;
  logic        reset;

  logic        in0_a_ready, in0_a_valid;
  logic [2:0]  in0_a_bits_opcode, in0_a_bits_param;
  logic [3:0]  in0_a_bits_size;
  logic [1:0]  in0_a_bits_source;
  logic [30:0] in0_a_bits_address;
  logic [7:0]  in0_a_bits_mask;
  logic [63:0] in0_a_bits_data;
  logic        in0_a_bits_corrupt;
  logic        in0_d_ready, in0_d_valid;
  logic [2:0]  in0_d_bits_opcode;
  logic [1:0]  in0_d_bits_param;
  logic [3:0]  in0_d_bits_size;
  logic [1:0]  in0_d_bits_source;
  logic        in0_d_bits_sink, in0_d_bits_denied;
  logic [63:0] in0_d_bits_data;
  logic        in0_d_bits_corrupt;

  logic        in1_a_ready, in1_a_valid;
  logic [2:0]  in1_a_bits_opcode, in1_a_bits_param;
  logic [3:0]  in1_a_bits_size;
  logic [1:0]  in1_a_bits_source;
  logic [30:0] in1_a_bits_address;
  logic [7:0]  in1_a_bits_mask;
  logic [63:0] in1_a_bits_data;
  logic        in1_a_bits_corrupt;
  logic        in1_d_ready, in1_d_valid;
  logic [2:0]  in1_d_bits_opcode;
  logic [1:0]  in1_d_bits_param;
  logic [3:0]  in1_d_bits_size;
  logic [1:0]  in1_d_bits_source;
  logic        in1_d_bits_sink, in1_d_bits_denied;
  logic [63:0] in1_d_bits_data;
  logic        in1_d_bits_corrupt;

  logic        out_a_ready, out_a_valid;
  logic [2:0]  out_a_bits_opcode, out_a_bits_param;
  logic [3:0]  out_a_bits_size;
  logic [2:0]  out_a_bits_source;
  logic [30:0] out_a_bits_address;
  logic [7:0]  out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic        out_a_bits_corrupt;
  logic        out_d_ready, out_d_valid;
  logic [2:0]  out_d_bits_opcode;
  logic [1:0]  out_d_bits_param;
  logic [3:0]  out_d_bits_size;
  logic [2:0]  out_d_bits_source;
  logic        out_d_bits_sink, out_d_bits_denied;
  logic [63:0] out_d_bits_data;
  logic        out_d_bits_corrupt;

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_AAD  = 3'd1;

  typedef struct {
    logic [2:0]  src;
    logic [30:0] addr;
    logic [63:0] data;
  } a_exp_t;

  typedef struct {
    logic        port;
    logic [1:0]  src;
    logic [63:0] data;
  } d_exp_t;

  a_exp_t aq[$];
  d_exp_t dq[$];
  a_exp_t ae;
  d_exp_t de;

  int checks = 0;
  int errors = 0;

  tl_client_arbiter_2to1 dut (
    .clock(clock), .reset(reset),
    .in0_a_ready(in0_a_ready), .in0_a_valid(in0_a_valid),
    .in0_a_bits_opcode(in0_a_bits_opcode),
    .in0_a_bits_param(in0_a_bits_param),
    .in0_a_bits_size(in0_a_bits_size),
    .in0_a_bits_source(in0_a_bits_source),
    .in0_a_bits_address(in0_a_bits_address),
    .in0_a_bits_mask(in0_a_bits_mask),
    .in0_a_bits_data(in0_a_bits_data),
    .in0_a_bits_corrupt(in0_a_bits_corrupt),
    .in0_d_ready(in0_d_ready), .in0_d_valid(in0_d_valid),
    .in0_d_bits_opcode(in0_d_bits_opcode),
    .in0_d_bits_param(in0_d_bits_param),
    .in0_d_bits_size(in0_d_bits_size),
    .in0_d_bits_source(in0_d_bits_source),
    .in0_d_bits_sink(in0_d_bits_sink),
    .in0_d_bits_denied(in0_d_bits_denied),
    .in0_d_bits_data(in0_d_bits_data),
    .in0_d_bits_corrupt(in0_d_bits_corrupt),
    .in1_a_ready(in1_a_ready), .in1_a_valid(in1_a_valid),
    .in1_a_bits_opcode(in1_a_bits_opcode),
    .in1_a_bits_param(in1_a_bits_param),
    .in1_a_bits_size(in1_a_bits_size),
    .in1_a_bits_source(in1_a_bits_source),
    .in1_a_bits_address(in1_a_bits_address),
    .in1_a_bits_mask(in1_a_bits_mask),
    .in1_a_bits_data(in1_a_bits_data),
    .in1_a_bits_corrupt(in1_a_bits_corrupt),
    .in1_d_ready(in1_d_ready), .in1_d_valid(in1_d_valid),
    .in1_d_bits_opcode(in1_d_bits_opcode),
    .in1_d_bits_param(in1_d_bits_param),
    .in1_d_bits_size(in1_d_bits_size),
    .in1_d_bits_source(in1_d_bits_source),
    .in1_d_bits_sink(in1_d_bits_sink),
    .in1_d_bits_denied(in1_d_bits_denied),
    .in1_d_bits_data(in1_d_bits_data),
    .in1_d_bits_corrupt(in1_d_bits_corrupt),
    .out_a_ready(out_a_ready), .out_a_valid(out_a_valid),
    .out_a_bits_opcode(out_a_bits_opcode),
    .out_a_bits_param(out_a_bits_param),
    .out_a_bits_size(out_a_bits_size),
    .out_a_bits_source(out_a_bits_source),
    .out_a_bits_address(out_a_bits_address),
    .out_a_bits_mask(out_a_bits_mask),
    .out_a_bits_data(out_a_bits_data),
    .out_a_bits_corrupt(out_a_bits_corrupt),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid),
    .out_d_bits_opcode(out_d_bits_opcode),
    .out_d_bits_param(out_d_bits_param),
    .out_d_bits_size(out_d_bits_size),
    .out_d_bits_source(out_d_bits_source),
    .out_d_bits_sink(out_d_bits_sink),
    .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data),
    .out_d_bits_corrupt(out_d_bits_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pa(input logic [2:0] src, input logic [30:0] addr,
                    input logic [63:0] dat);
    aq.push_back('{src: src, addr: addr, data: dat});
  endtask

  // Present one A beat on requester n and hold it until accepted.
  task automatic drv(input int n, input logic [2:0] op,
                     input logic [3:0] sz, input logic [1:0] src,
                     input logic [30:0] addr, input logic [63:0] dat);
    int t;
    logic rdy;
    if (n == 0) begin
      in0_a_bits_opcode = op; in0_a_bits_size = sz;
      in0_a_bits_source = src; in0_a_bits_address = addr;
      in0_a_bits_data = dat; in0_a_valid = 1'b1;
    end else begin
      in1_a_bits_opcode = op; in1_a_bits_size = sz;
      in1_a_bits_source = src; in1_a_bits_address = addr;
      in1_a_bits_data = dat; in1_a_valid = 1'b1;
    end
    t = 0;
    rdy = 1'b0;
    while (!rdy && t < 40) begin
      @(negedge clock);
      rdy = (n == 0) ? in0_a_ready : in1_a_ready;
      t++;
    end
    if (!rdy) chk("drv_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    if (n == 0) in0_a_valid = 1'b0;
    else in1_a_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_a_valid && out_a_ready) begin
      if (aq.size() == 0) begin
        chk("a_unexpected", {33'd0, out_a_bits_address}, 64'd0 - 64'd1);
      end else begin
        ae = aq.pop_front();
        chk("a_source", out_a_bits_source, ae.src);
        chk("a_addr", out_a_bits_address, ae.addr);
        chk("a_data", out_a_bits_data, ae.data);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (in0_d_valid && in0_d_ready) begin
        if (dq.size() == 0) chk("d0_unexpected", 64'd1, 64'd0);
        else begin
          de = dq.pop_front();
          chk("d0_port", 64'd0, de.port);
          chk("d0_src", in0_d_bits_source, de.src);
          chk("d0_data", in0_d_bits_data, de.data);
        end
      end
      if (in1_d_valid && in1_d_ready) begin
        if (dq.size() == 0) chk("d1_unexpected", 64'd1, 64'd0);
        else begin
          de = dq.pop_front();
          chk("d1_port", 64'd1, de.port);
          chk("d1_src", in1_d_bits_source, de.src);
          chk("d1_data", in1_d_bits_data, de.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in0_a_valid = 0; in0_a_bits_opcode = 0; in0_a_bits_param = 0;
    in0_a_bits_size = 0; in0_a_bits_source = 0;
    in0_a_bits_address = 0; in0_a_bits_mask = 8'hff;
    in0_a_bits_data = 0; in0_a_bits_corrupt = 0;
    in1_a_valid = 0; in1_a_bits_opcode = 0; in1_a_bits_param = 0;
    in1_a_bits_size = 0; in1_a_bits_source = 0;
    in1_a_bits_address = 0; in1_a_bits_mask = 8'hff;
    in1_a_bits_data = 0; in1_a_bits_corrupt = 0;
    in0_d_ready = 1; in1_d_ready = 1; out_a_ready = 1;
    out_d_valid = 1; out_d_bits_opcode = OP_AAD;
    out_d_bits_param = 0; out_d_bits_size = 4'd3;
    out_d_bits_source = 3'b000; out_d_bits_sink = 0;
    out_d_bits_denied = 0; out_d_bits_data = 0;
    out_d_bits_corrupt = 0;
    in0_a_valid = 1;

    // Reset holds every handshake output low.
    #3;
    chk("rst_out_a_valid", out_a_valid, 0);
    chk("rst_in0_a_ready", in0_a_ready, 0);
    chk("rst_in1_a_ready", in1_a_ready, 0);
    chk("rst_in0_d_valid", in0_d_valid, 0);
    chk("rst_out_d_ready", out_d_ready, 0);
    @(posedge clock); #1;
    reset = 0; in0_a_valid = 0; out_d_valid = 0;
    @(posedge clock); #1;

    // Tie every cycle: grants alternate starting with in0.
    pa(3'b000, 31'h200, 64'd0);
    pa(3'b101, 31'h300, 64'd0);
    pa(3'b000, 31'h204, 64'd0);
    pa(3'b101, 31'h304, 64'd0);
    fork
      begin
        drv(0, OP_GET, 4'd3, 2'd0, 31'h200, 64'd0);
        drv(0, OP_GET, 4'd3, 2'd0, 31'h204, 64'd0);
      end
      begin
        drv(1, OP_GET, 4'd3, 2'd1, 31'h300, 64'd0);
        drv(1, OP_GET, 4'd3, 2'd1, 31'h304, 64'd0);
      end
    join

    // 8-beat PutFull from in0 with a gap locks out in1's Get.
    for (int k = 0; k < 8; k++)
      pa(3'b001, 31'h1000 + 31'(8 * k), 64'hA0 + 64'(k));
    pa(3'b110, 31'h2000, 64'd0);
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          drv(0, OP_PUTF, 4'd6, 2'd1, 31'h1000 + 31'(8 * k),
              64'hA0 + 64'(k));
          if (k == 3) begin
            repeat (2) begin
              @(negedge clock);
              chk("gap_in1_ready", in1_a_ready, 0);
              chk("gap_out_valid", out_a_valid, 0);
              @(posedge clock); #1;
            end
          end
        end
      end
      drv(1, OP_GET, 4'd3, 2'd2, 31'h2000, 64'd0);
    join

    // Lone in0 Get is forwarded in the same cycle.
    pa(3'b011, 31'h100, 64'd0);
    in0_a_bits_opcode = OP_GET; in0_a_bits_size = 4'd3;
    in0_a_bits_source = 2'd3; in0_a_bits_address = 31'h100;
    in0_a_bits_data = 64'd0; in0_a_valid = 1;
    @(negedge clock);
    chk("t1_out_valid", out_a_valid, 1);
    chk("t1_in0_ready", in0_a_ready, 1);
    chk("t1_in1_ready", in1_a_ready, 0);
    chk("t1_source", out_a_bits_source, 3'b011);
    @(posedge clock); #1;
    in0_a_valid = 0;

    // Backpressure: in1 held in HOLD while in0 rises.
    pa(3'b100, 31'h400, 64'd0);
    pa(3'b001, 31'h500, 64'd0);
    out_a_ready = 0;
    fork
      drv(1, OP_GET, 4'd3, 2'd0, 31'h400, 64'd0);
      begin
        @(posedge clock); #1;
        drv(0, OP_GET, 4'd3, 2'd1, 31'h500, 64'd0);
      end
      begin
        @(negedge clock);
        chk("hold_c1_src", out_a_bits_source, 3'b100);
        @(posedge clock);
        repeat (2) begin
          @(negedge clock);
          chk("hold_addr", out_a_bits_address, 31'h400);
          chk("hold_in0_ready", in0_a_ready, 0);
          @(posedge clock);
        end
        #1 out_a_ready = 1;
      end
    join

    // Two-beat AccessAckData to source 3'b110 lands on in1 only.
    dq.push_back('{port: 1'b1, src: 2'b10, data: 64'hD0});
    dq.push_back('{port: 1'b1, src: 2'b10, data: 64'hD1});
    in0_d_ready = 1; in1_d_ready = 0;
    out_d_bits_opcode = OP_AAD; out_d_bits_size = 4'd4;
    out_d_bits_source = 3'b110; out_d_bits_data = 64'hD0;
    out_d_valid = 1;
    @(negedge clock);
    chk("d_in1_valid", in1_d_valid, 1);
    chk("d_in0_valid", in0_d_valid, 0);
    chk("d_ready_lo", out_d_ready, 0);
    @(posedge clock); #1;
    in1_d_ready = 1;
    @(negedge clock);
    chk("d_ready_hi", out_d_ready, 1);
    @(posedge clock); #1;
    out_d_bits_data = 64'hD1;
    @(negedge clock);
    chk("d_b1_in0_valid", in0_d_valid, 0);
    @(posedge clock); #1;
    out_d_valid = 0;

    // Reset mid-burst, then in0 must win the next tie.
    pa(3'b000, 31'h3000, 64'hB0);
    pa(3'b000, 31'h3008, 64'hB1);
    pa(3'b000, 31'h3010, 64'hB2);
    for (int k = 0; k < 3; k++)
      drv(0, OP_PUTF, 4'd6, 2'd0, 31'h3000 + 31'(8 * k),
          64'hB0 + 64'(k));
    in0_a_bits_address = 31'h3018; in0_a_bits_data = 64'hB3;
    in0_a_valid = 1;
    out_d_valid = 1; out_d_bits_source = 3'b100;
    reset = 1;
    #2;
    chk("mrst_out_valid", out_a_valid, 0);
    chk("mrst_in0_ready", in0_a_ready, 0);
    chk("mrst_in1_d_valid", in1_d_valid, 0);
    chk("mrst_out_d_ready", out_d_ready, 0);
    @(posedge clock); #1;
    reset = 0; in0_a_valid = 0; out_d_valid = 0;
    @(posedge clock); #1;
    pa(3'b000, 31'h600, 64'd0);
    pa(3'b101, 31'h700, 64'd0);
    fork
      drv(0, OP_GET, 4'd3, 2'd0, 31'h600, 64'd0);
      drv(1, OP_GET, 4'd3, 2'd1, 31'h700, 64'd0);
    join

    repeat (3) @(posedge clock);
    #1;
    chk("a_queue_empty", 64'(aq.size()), 0);
    chk("d_queue_empty", 64'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
